// File: rtl/cntlz_pkg.sv
// Shared types and helpers for the pipelined bit-scan unit (cntlz_pipe).
package cntlz_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        CLZ = 3'b000,
        CLO = 3'b001,
        CTZ = 3'b010,
        CTO = 3'b011,
        POP = 3'b100
    } scan_mode_e;

    function automatic int cw_f(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/cntlz_byte.sv
// 8-bit leading-zero LUT (0..8); with CNTLZ_POPCNT_EN it also returns the byte popcount.
module cntlz_byte
    import cntlz_pkg::*;
(
    input  logic [BYTE_W-1:0] data,
    output logic [3:0]        lz
`ifdef CNTLZ_POPCNT_EN
    ,
    output logic [3:0]        pop
`endif
);

    // Ascending scan: the highest set bit is the last to assign.
    always_comb begin
        lz = 4'd8;
        for (int i = 0; i < BYTE_W; i++) begin
            if (data[i]) lz = 4'(BYTE_W - 1 - i);
        end
    end

`ifdef CNTLZ_POPCNT_EN
    always_comb begin
        pop = 4'($countones(data));
    end
`endif

endmodule

// File: rtl/cntlz_pipe.sv
// Two-stage valid/ready bit scan (CLZ/CLO/CTZ/CTO); CNTLZ_POPCNT_EN adds popcount on in_mode[2].
module cntlz_pipe
    import cntlz_pkg::*;
#(
    parameter int  WIDTH = 64,
    parameter int  TAGW  = 4,
    localparam int CW    = cw_f(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_mode,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_cnt,
    output logic             out_all,
    output logic [TAGW-1:0]  out_tag
);

    localparam int NB = WIDTH / BYTE_W;

    scan_mode_e       mode;
    logic [WIDTH-1:0] rev;
    logic [WIDTH-1:0] cond;
    logic [3:0]       byte_lz [NB];
    logic             s1_valid;
    logic [3:0]       s1_cnt [NB];
    logic [TAGW-1:0]  s1_tag;
    logic             s2_load;
    logic [CW-1:0]    merged_cnt;
    logic             merged_all;

`ifdef CNTLZ_POPCNT_EN
    logic [3:0] byte_pop [NB];
    logic       s1_pop;
`else
    logic unused_mode;
    assign unused_mode = in_mode[2];
`endif

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;

    // Trailing scans reuse the leading-zero LUTs on the bit-reversed operand.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) rev[i] = in_data[WIDTH-1-i];
        mode = scan_mode_e'({1'b0, in_mode[1:0]});
`ifdef CNTLZ_POPCNT_EN
        if (in_mode[2]) mode = POP;
`endif
        case (mode)
            CLZ:     cond = in_data;
            CLO:     cond = ~in_data;
            CTZ:     cond = rev;
            CTO:     cond = ~rev;
            default: cond = in_data;
        endcase
    end

    for (genvar b = 0; b < NB; b++) begin : g_byte
        cntlz_byte u_byte (
            .data (cond[BYTE_W*b +: BYTE_W]),
            .lz   (byte_lz[b])
`ifdef CNTLZ_POPCNT_EN
            ,
            .pop  (byte_pop[b])
`endif
        );
    end

    // ---- stage 1: per-byte counts ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s1_valid <= 1'b0;
        else if (in_ready) s1_valid <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            s1_tag <= in_tag;
            for (int b = 0; b < NB; b++) begin
`ifdef CNTLZ_POPCNT_EN
                s1_cnt[b] <= in_mode[2] ? byte_pop[b] : byte_lz[b];
`else
                s1_cnt[b] <= byte_lz[b];
`endif
            end
`ifdef CNTLZ_POPCNT_EN
            s1_pop <= in_mode[2];
`endif
        end
    end

    // ---- stage 2: MSB-first priority merge (or popcount sum) ----
    always_comb begin
        logic found;
        found      = 1'b0;
        merged_cnt = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (!found) begin
                merged_cnt = merged_cnt + CW'(s1_cnt[i]);
                if (s1_cnt[i] != 4'd8) found = 1'b1;
            end
        end
        merged_all = !found;
`ifdef CNTLZ_POPCNT_EN
        if (s1_pop) begin
            merged_cnt = '0;
            for (int i = 0; i < NB; i++) merged_cnt = merged_cnt + CW'(s1_cnt[i]);
            merged_all = (merged_cnt == CW'(WIDTH));
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_cnt   <= '0;
            out_all   <= 1'b0;
            out_tag   <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_cnt <= merged_cnt;
                out_all <= merged_all;
                out_tag <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_cntlz_pipe.sv
// Bench for cntlz_pipe (WIDTH=64): directed corners plus random stream against a bit-level scan model.
module tb_cntlz_pipe;

    localparam int WIDTH = 64;
    localparam int TAGW  = 4;
    localparam int CW    = 7;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [WIDTH-1:0] in_data;
    logic [2:0]      in_mode;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [CW-1:0]   out_cnt;
    logic            out_all;
    logic [TAGW-1:0] out_tag;

    typedef struct {
        int              cnt;
        bit              all;
        logic [TAGW-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    logic [CW-1:0]   h_cnt;
    logic            h_all;
    logic [TAGW-1:0] h_tag;
    bit              h_vld = 1'b0;

    cntlz_pipe #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cnt   (out_cnt),
        .out_all   (out_all),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", nm, got, exp);
    endtask

    // Walk the bits in scan order and count the run of matching bits.
    function automatic int ref_count(input logic [63:0] d, input logic [2:0] m);
        int n   = 0;
        bit run = 1'b1;
        bit target;
`ifdef CNTLZ_POPCNT_EN
        if (m[2]) return $countones(d);
`endif
        target = m[0];
        for (int k = 0; k < 64; k++) begin
            int pos;
            pos = m[1] ? k : 63 - k;
            if (run && d[pos] == target) n++;
            else run = 1'b0;
        end
        return n;
    endfunction

    function automatic logic [63:0] rnd_data();
        logic [63:0] r;
        int          s;
        r = {$urandom(), $urandom()};
        s = $urandom_range(0, 63);
        return $urandom_range(0, 1) ? (r >> s) : (r << s);
    endfunction

    // Scoreboard: deliveries, stall stability and accepts, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            h_vld = 1'b0;
        end else begin
            if (h_vld) begin
                chk("stall_vld", out_valid, 1);
                chk("stall_cnt", out_cnt, h_cnt);
                chk("stall_all", out_all, h_all);
                chk("stall_tag", out_tag, h_tag);
            end
            h_vld = out_valid && !out_ready;
            h_cnt = out_cnt;
            h_all = out_all;
            h_tag = out_tag;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_cnt", out_cnt, e.cnt);
                    chk("sb_all", out_all, e.all);
                    chk("sb_tag", out_tag, e.tag);
                end
            end
            if (in_valid && in_ready) begin
                e.cnt = ref_count(in_data, in_mode);
                e.all = (e.cnt == WIDTH);
                e.tag = in_tag;
                exp_q.push_back(e);
            end
        end
    end

    // One operand through an idle pipe with out_ready high.
    task automatic run_one(input logic [63:0] d, input logic [2:0] m, input logic [3:0] t,
                           input int ecnt, input bit eall, input string nm);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        in_tag   = t;
        @(negedge clk) chk({nm, "_rdy"}, in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk) chk({nm, "_early"}, out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_vld"}, out_valid, 1);
        chk({nm, "_cnt"}, out_cnt, ecnt);
        chk({nm, "_all"}, out_all, eall);
        chk({nm, "_tag"}, out_tag, t);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          idx;
        int          cyc;
        bit          fire;
        logic [63:0] d;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 3'b000;
        in_tag    = '0;
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_vld", out_valid, 0);
        chk("rst_cnt", out_cnt, 0);
        chk("rst_all", out_all, 0);
        chk("rst_tag", out_tag, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk) chk("rst_rdy", in_ready, 1);

        run_one(64'h0000_0000_0001_0000, 3'b000, 4'h3, 47, 1'b0, "clz47");
        run_one(64'hFFFF_FFFF_FFFF_FFFF, 3'b001, 4'h5, 64, 1'b1, "clo_all");
        run_one(64'h0,                   3'b010, 4'h6, 64, 1'b1, "ctz_zero");
        run_one(64'h0000_0000_0000_00FF, 3'b011, 4'h7, 8,  1'b0, "cto_ff");
        run_one(64'h8000_0000_0000_0000, 3'b000, 4'h8, 0,  1'b0, "clz_msb");
        run_one(64'h0000_0000_0000_0001, 3'b000, 4'h9, 63, 1'b0, "clz63");
`ifdef CNTLZ_POPCNT_EN
        run_one(64'hF0F0_0000_0000_0001, 3'b100, 4'hA, 9,  1'b0, "pop9");
`else
        run_one(64'hF0F0_0000_0000_0001, 3'b100, 4'hA, 0,  1'b0, "pop_off");
`endif

        // Back-pressure: two accepted, third waits for the first delivery.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = rnd_data();
        in_mode   = 3'($urandom_range(0, 3));
        in_tag    = 4'd9;
        @(negedge clk) chk("bp_rdy0", in_ready, 1);
        @(posedge clk);
        #1;
        in_data = rnd_data();
        in_tag  = 4'd10;
        @(negedge clk) chk("bp_rdy1", in_ready, 1);
        @(posedge clk);
        #1;
        in_data = rnd_data();
        in_tag  = 4'd11;
        @(negedge clk) chk("bp_full", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        chk("bp_hold", in_ready, 0);
        chk("bp_tag0", out_tag, 9);
        @(posedge clk);
        #1 out_ready = 1'b1;
        #1 chk("bp_comb", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_vld1", out_valid, 1);
        chk("bp_tag1", out_tag, 10);
        repeat (4) @(posedge clk);

        // Random stream, tags 0..15, out_ready pattern 1,0,0,1.
        idx = 0;
        cyc = 0;
        d   = rnd_data();
        while (idx < 16 && cyc < 300) begin
            @(posedge clk);
            #1;
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            in_valid  = 1'b1;
            in_data   = d;
            in_tag    = idx[3:0];
            in_mode   = {1'b0, 2'(idx % 4)};
            @(negedge clk) fire = in_ready;
            if (fire) begin
                idx++;
                d = rnd_data();
            end
            cyc++;
        end
        chk("stream_sent", idx, 16);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk) chk("stream_drain", exp_q.size(), 0);

        // Reset while two results are in flight.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = rnd_data();
        in_mode   = 3'b000;
        in_tag    = 4'd12;
        @(posedge clk);
        #1;
        in_data = rnd_data();
        in_tag  = 4'd13;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk) chk("rf_vld", out_valid, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("rst_async_vld", out_valid, 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk) chk("rst_nostale", out_valid, 0);
        end
        d = 64'h0000_0F00_0000_0000;
        run_one(d, 3'b000, 4'hE, ref_count(d, 3'b000), 1'b0, "post_rst");

        repeat (2) @(posedge clk);
        @(negedge clk) chk("final_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
